// File: rtl/alu_issue_scheduler_pkg.sv
// Shared sizing and lane-binding types for the ALU issue scheduler.
package alu_sched_pkg;

  localparam int unsigned NUM_FU     = 3;
  localparam int unsigned RS_ENTRIES = 8;
  localparam int unsigned LAT_W      = 2;
  localparam int unsigned IDX_W      = $clog2(RS_ENTRIES);

  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [LAT_W-1:0] lat_t;

  typedef struct packed {
    logic valid;
    idx_t idx;
  } lane_bind_t;

endpackage

// File: rtl/alu_issue_scheduler_if.sv
// RS-side request/grant and ALU-side issue signals of the issue scheduler.
interface alu_issue_scheduler_if;
  import alu_sched_pkg::*;

  logic [RS_ENTRIES-1:0]       rs_req;
  logic [RS_ENTRIES*LAT_W-1:0] rs_lat;
  logic [RS_ENTRIES-1:0]       rs_grant;
  logic [NUM_FU-1:0]           issue_valid;
  logic [NUM_FU*IDX_W-1:0]     issue_idx;
  logic [NUM_FU-1:0]           fu_busy;

  modport master (
    input  rs_req, rs_lat,
    output rs_grant, issue_valid, issue_idx, fu_busy
  );

  modport slave (
    output rs_req, rs_lat,
    input  rs_grant, issue_valid, issue_idx, fu_busy
  );

endinterface

// File: rtl/alu_issue_scheduler_rr_multi_picker.sv
// Round-robin multi-grant picker: the k-th requester found from rr_ptr binds to the k-th free lane.
module rr_multi_picker
  import alu_sched_pkg::*;
(
  input  logic [RS_ENTRIES-1:0] req,
  input  logic [NUM_FU-1:0]     free,
  input  idx_t                  rr_ptr,
  output lane_bind_t [NUM_FU-1:0] binds,
  output logic [RS_ENTRIES-1:0] grant,
  output idx_t                  next_ptr
);

  logic [NUM_FU-1:0] taken;
  idx_t              entry;
  logic              placed;

  always_comb begin
    binds    = '0;
    grant    = '0;
    next_ptr = rr_ptr;
    taken    = '0;
    entry    = '0;
    placed   = 1'b0;
    for (int unsigned o = 0; o < RS_ENTRIES; o++) begin
      // RS_ENTRIES is a power of two, so the index add wraps the scan naturally.
      entry  = rr_ptr + idx_t'(o);
      placed = 1'b0;
      if (req[entry]) begin
        for (int unsigned f = 0; f < NUM_FU; f++) begin
          if (!placed && free[f] && !taken[f]) begin
            binds[f].valid = 1'b1;
            binds[f].idx   = entry;
            taken[f]       = 1'b1;
            grant[entry]   = 1'b1;
            placed         = 1'b1;
            next_ptr       = entry + idx_t'(1);
          end
        end
      end
    end
  end

endmodule

// File: rtl/alu_issue_scheduler.sv
// Binds ready RS entries to free ALU lanes each cycle and tracks multi-cycle lane occupancy.
module alu_issue_scheduler
  import alu_sched_pkg::*;
(
  input  logic clk,
  input  logic rstn,
  input  logic flush,
  alu_issue_scheduler_if.master sched
);

  idx_t                    rr_ptr;
  idx_t                    next_ptr;
  lat_t                    busy_cnt [NUM_FU];
  lat_t                    busy_nxt [NUM_FU];
  lat_t                    lat_of   [RS_ENTRIES];
  logic [NUM_FU-1:0]       free;
  logic [RS_ENTRIES-1:0]   req_eff;
  logic [RS_ENTRIES-1:0]   grant;
  lane_bind_t [NUM_FU-1:0] binds;
  logic [NUM_FU-1:0]       issue_valid_q;
  logic [NUM_FU*IDX_W-1:0] issue_idx_q;
  logic [NUM_FU-1:0]       fu_busy_q;

  always_comb begin
    free = '0;
    for (int unsigned f = 0; f < NUM_FU; f++) begin
      free[f] = (busy_cnt[f] == '0);
    end
  end

  always_comb begin
    for (int unsigned e = 0; e < RS_ENTRIES; e++) begin
      lat_of[e] = sched.rs_lat[e*LAT_W +: LAT_W];
    end
  end

  // Masking requests rather than grants also keeps rr_ptr from advancing under reset/flush.
  assign req_eff = (rstn && !flush) ? sched.rs_req : '0;

  rr_multi_picker u_picker (
    .req      (req_eff),
    .free     (free),
    .rr_ptr   (rr_ptr),
    .binds    (binds),
    .grant    (grant),
    .next_ptr (next_ptr)
  );

  always_comb begin
    for (int unsigned f = 0; f < NUM_FU; f++) begin
      busy_nxt[f] = '0;
      if (binds[f].valid) begin
        busy_nxt[f] = lat_of[binds[f].idx];
      end else if (busy_cnt[f] != '0) begin
        busy_nxt[f] = busy_cnt[f] - lat_t'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rr_ptr        <= '0;
      issue_valid_q <= '0;
      issue_idx_q   <= '0;
      fu_busy_q     <= '0;
      for (int unsigned f = 0; f < NUM_FU; f++) begin
        busy_cnt[f] <= '0;
      end
    end else if (flush) begin
      rr_ptr        <= '0;
      issue_valid_q <= '0;
      fu_busy_q     <= '0;
      for (int unsigned f = 0; f < NUM_FU; f++) begin
        busy_cnt[f] <= '0;
      end
    end else begin
      rr_ptr <= next_ptr;
      for (int unsigned f = 0; f < NUM_FU; f++) begin
        busy_cnt[f]      <= busy_nxt[f];
        fu_busy_q[f]     <= (busy_nxt[f] != '0);
        issue_valid_q[f] <= binds[f].valid;
        if (binds[f].valid) begin
          issue_idx_q[f*IDX_W +: IDX_W] <= binds[f].idx;
        end
      end
    end
  end

  assign sched.rs_grant    = grant;
  assign sched.issue_valid = issue_valid_q;
  assign sched.issue_idx   = issue_idx_q;
  assign sched.fu_busy     = fu_busy_q;

endmodule

// File: tb/tb_alu_issue_scheduler.sv
// Scoreboard bench for alu_issue_scheduler: a reference model predicts grants and the next-cycle issue state.
module tb_alu_issue_scheduler;
  import alu_sched_pkg::*;

  logic clk = 1'b0;
  logic rstn;
  logic flush;

  alu_issue_scheduler_if sched_if ();

  alu_issue_scheduler dut (
    .clk   (clk),
    .rstn  (rstn),
    .flush (flush),
    .sched (sched_if)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NUM_FU-1:0]       valid;
    logic [NUM_FU*IDX_W-1:0] idx;
  } exp_t;

  exp_t sb[$];

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  int unsigned             m_ptr;
  int unsigned             m_cnt [NUM_FU];
  logic [NUM_FU-1:0]       m_valid;
  logic [NUM_FU*IDX_W-1:0] m_idx;
  bit                      m_known = 1'b0;

  logic [RS_ENTRIES-1:0]   obs_grant;
  logic [NUM_FU-1:0]       obs_valid;
  logic [NUM_FU-1:0]       obs_busy;
  logic [NUM_FU*IDX_W-1:0] obs_idx;
  int unsigned             gcount [RS_ENTRIES];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int unsigned lat_at(input logic [RS_ENTRIES*LAT_W-1:0] v, input int unsigned e);
    return int'(v[e*LAT_W +: LAT_W]);
  endfunction

  // One clock: sample at negedge, check against model, advance model, return 1 time unit past posedge.
  task automatic step();
    logic [RS_ENTRIES-1:0] req;
    logic [RS_ENTRIES-1:0] exp_grant;
    logic [NUM_FU-1:0]     exp_busy;
    logic [NUM_FU-1:0]     bound;
    int unsigned           bidx [NUM_FU];
    int unsigned           free_l[$];
    int unsigned           k;
    int unsigned           last;
    int unsigned           e;
    int unsigned           lane;
    exp_t                  x;
    @(negedge clk);
    obs_grant = sched_if.rs_grant;
    obs_valid = sched_if.issue_valid;
    obs_idx   = sched_if.issue_idx;
    obs_busy  = sched_if.fu_busy;
    if (sb.size() > 0) begin
      x = sb.pop_front();
      check_eq("issue_valid", obs_valid, x.valid);
      check_eq("issue_idx", obs_idx, x.idx);
    end
    if (m_known) begin
      exp_busy = '0;
      for (int f = 0; f < NUM_FU; f++) exp_busy[f] = (m_cnt[f] != 0);
      check_eq("fu_busy", obs_busy, exp_busy);
    end
    req = (rstn === 1'b1 && flush === 1'b0) ? sched_if.rs_req : '0;
    for (int f = 0; f < NUM_FU; f++) begin
      bidx[f] = 0;
      if (m_cnt[f] == 0) free_l.push_back(f);
    end
    exp_grant = '0;
    bound     = '0;
    k         = 0;
    last      = m_ptr;
    for (int o = 0; o < RS_ENTRIES; o++) begin
      e = (m_ptr + o) % RS_ENTRIES;
      if (req[e] && k < free_l.size()) begin
        lane         = free_l[k];
        k++;
        exp_grant[e] = 1'b1;
        bound[lane]  = 1'b1;
        bidx[lane]   = e;
        last         = e;
      end
    end
    check_eq("rs_grant", obs_grant, exp_grant);
    for (int i = 0; i < RS_ENTRIES; i++) if (obs_grant[i] === 1'b1) gcount[i]++;
    if (rstn !== 1'b1) begin
      m_ptr   = 0;
      m_valid = '0;
      m_idx   = '0;
      m_known = 1'b1;
      for (int f = 0; f < NUM_FU; f++) m_cnt[f] = 0;
    end else if (flush === 1'b1) begin
      m_ptr   = 0;
      m_valid = '0;
      for (int f = 0; f < NUM_FU; f++) m_cnt[f] = 0;
    end else begin
      for (int f = 0; f < NUM_FU; f++) begin
        if (bound[f]) begin
          m_valid[f]                 = 1'b1;
          m_idx[f*IDX_W +: IDX_W]    = bidx[f][IDX_W-1:0];
          m_cnt[f]                   = lat_at(sched_if.rs_lat, bidx[f]);
        end else begin
          m_valid[f] = 1'b0;
          if (m_cnt[f] > 0) m_cnt[f]--;
        end
      end
      if (k > 0) m_ptr = (last + 1) % RS_ENTRIES;
    end
    if (m_known) begin
      x.valid = m_valid;
      x.idx   = m_idx;
      sb.push_back(x);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int unsigned mn;
    int unsigned mx;
    for (int f = 0; f < NUM_FU; f++) m_cnt[f] = 0;
    for (int i = 0; i < RS_ENTRIES; i++) gcount[i] = 0;
    m_ptr           = 0;
    rstn            = 1'b0;
    flush           = 1'b0;
    sched_if.rs_req = 8'hFF;
    sched_if.rs_lat = '0;

    // Reset held with every entry requesting.
    for (int c = 0; c < 2; c++) begin
      step();
      check_eq("rst_grant", obs_grant, 8'h00);
    end
    check_eq("rst_valid", obs_valid, 3'b000);
    check_eq("rst_busy", obs_busy, 3'b000);

    // Two requests from rr_ptr=0.
    rstn = 1'b1;
    sched_if.rs_req = 8'b0000_0110;
    step();
    check_eq("t2_grant", obs_grant, 8'b0000_0110);
    sched_if.rs_req = 8'h00;
    step();
    check_eq("t2_valid", obs_valid, 3'b011);
    check_eq("t2_idx", obs_idx, 9'b000_010_001);

    // Move rr_ptr to 6, then all request: wrap grants 6,7,0.
    sched_if.rs_req = 8'b0011_1000;
    step();
    sched_if.rs_req = 8'h00;
    step();
    sched_if.rs_req = 8'hFF;
    step();
    check_eq("t3_grant", obs_grant, 8'b1100_0001);
    sched_if.rs_req = 8'h00;
    step();
    check_eq("t3_valid", obs_valid, 3'b111);
    check_eq("t3_idx", obs_idx, 9'b000_111_110);

    // Entry 3 lat=2 on lane0, entries 4,5 to lanes 1,2.
    sched_if.rs_req = 8'b0011_1000;
    sched_if.rs_lat[3*LAT_W +: LAT_W] = 2'd2;
    step();
    check_eq("t4_grant", obs_grant, 8'b0011_1000);
    sched_if.rs_req = 8'h00;
    sched_if.rs_lat = '0;
    step();
    check_eq("t4_busy_c1", obs_busy, 3'b001);
    check_eq("t4_idx", obs_idx, 9'b101_100_011);
    sched_if.rs_req = 8'h02;
    step();
    check_eq("t4_busy_c2", obs_busy, 3'b001);
    check_eq("t4_grant_c2", obs_grant, 8'h02);
    sched_if.rs_req = 8'h04;
    step();
    check_eq("t4_busy_c3", obs_busy, 3'b000);
    check_eq("t4_valid_c3", obs_valid, 3'b010);
    check_eq("t4_grant_c3", obs_grant, 8'h04);
    sched_if.rs_req = 8'h00;
    step();
    check_eq("t4_regrant_valid", obs_valid, 3'b001);
    check_eq("t4_regrant_idx", obs_idx[2:0], 3'd2);

    // Flush while lane2 holds a lat=3 op.
    sched_if.rs_req = 8'b0011_1000;
    sched_if.rs_lat[5*LAT_W +: LAT_W] = 2'd3;
    step();
    flush = 1'b1;
    sched_if.rs_req = 8'h0F;
    sched_if.rs_lat = '0;
    step();
    check_eq("t5_flush_grant", obs_grant, 8'h00);
    check_eq("t5_busy_pre", obs_busy, 3'b100);
    flush = 1'b0;
    sched_if.rs_req = 8'h00;
    step();
    check_eq("t5_valid_post", obs_valid, 3'b000);
    check_eq("t5_busy_post", obs_busy, 3'b000);
    sched_if.rs_req = 8'hFF;
    step();
    check_eq("t5_ptr_zero", obs_grant, 8'h07);
    sched_if.rs_req = 8'h00;
    step();

    // Starvation: everyone requests for 8 cycles.
    for (int i = 0; i < RS_ENTRIES; i++) gcount[i] = 0;
    sched_if.rs_req = 8'hFF;
    for (int c = 0; c < 8; c++) step();
    mn = gcount[0];
    mx = gcount[0];
    for (int i = 1; i < RS_ENTRIES; i++) begin
      if (gcount[i] < mn) mn = gcount[i];
      if (gcount[i] > mx) mx = gcount[i];
    end
    check_eq("t6_min_ge1", 32'(mn >= 1), 32'd1);
    check_eq("t6_spread", 32'(mx - mn <= 1), 32'd1);

    // Random traffic with occasional flush and reset.
    for (int c = 0; c < 80; c++) begin
      sched_if.rs_req = RS_ENTRIES'($urandom);
      sched_if.rs_lat = (RS_ENTRIES*LAT_W)'($urandom);
      flush = ($urandom_range(0, 15) == 0);
      rstn  = ($urandom_range(0, 31) != 0);
      step();
    end
    rstn  = 1'b1;
    flush = 1'b0;
    sched_if.rs_req = 8'h00;
    for (int c = 0; c < 5; c++) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
